// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch/decode/execute sequencer
// Drives pc, ROM strobe and IR load; the CU decides execute length and branches.
module fetch_sequencer #(
  parameter int                  PC_WIDTH   = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  FETCH_WAIT = 0,
  parameter int                  CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cu_done,
  input  logic                 branch_taken,
  input  logic [PC_WIDTH-1:0]  branch_target,
  input  logic                 halt_req,
  input  logic                 resume,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 rom_read_enable,
  output logic                 ir_load,
  output logic [2:0]           state,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_DECODE  = 3'd3,
    S_EXECUTE = 3'd4,
    S_HALT    = 3'd5
  } state_e;

  // FETCH itself is the first ROM cycle, so WAIT only covers the remaining ones.
  localparam logic [3:0] WAIT_LOAD = (FETCH_WAIT > 0) ? 4'(FETCH_WAIT - 1) : 4'd0;

  state_e               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic [3:0]           wait_q, wait_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      wait_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      wait_q    <= wait_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    wait_d    = wait_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (FETCH_WAIT == 0) begin
          state_d = S_DECODE;
        end else begin
          wait_d  = WAIT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_q == 4'd0) state_d = S_DECODE;
        else                wait_d  = wait_q - 4'd1;
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        // Retire: pc, counter and halt decision all commit on this one edge.
        if (cu_done) begin
          pc_d      = branch_taken ? branch_target : pc_q + PC_WIDTH'(1);
          retired_d = retired_q + CNT_WIDTH'(1);
          state_d   = halt_req ? S_HALT : S_FETCH;
        end
      end
      S_HALT: begin
        if (resume) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pc              = pc_q;
  assign retired         = retired_q;
  assign state           = state_q;
  assign rom_read_enable = (state_q == S_FETCH) || (state_q == S_WAIT);
  assign ir_load         = (state_q == S_DECODE);
  assign halted          = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
// Three instances: defaults, FETCH_WAIT=2, and a 4-bit pc starting at 4'hF.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Instance 0: defaults
  logic       rst0 = 1'b1, cu0 = 1'b0, br0 = 1'b0, hreq0 = 1'b0, res0 = 1'b0;
  logic [7:0] tgt0 = 8'h00, pc0;
  logic       rom0, ir0, halt0;
  logic [2:0] st0;
  logic [15:0] ret0;

  fetch_sequencer u0 (
    .clk(clk), .reset(rst0), .cu_done(cu0), .branch_taken(br0), .branch_target(tgt0),
    .halt_req(hreq0), .resume(res0), .pc(pc0), .rom_read_enable(rom0), .ir_load(ir0),
    .state(st0), .halted(halt0), .retired(ret0)
  );

  // Instance 1: two ROM wait states
  logic       rst1 = 1'b1, cu1 = 1'b0, br1 = 1'b0, hreq1 = 1'b0, res1 = 1'b0;
  logic [7:0] tgt1 = 8'h00, pc1;
  logic       rom1, ir1, halt1;
  logic [2:0] st1;
  logic [15:0] ret1;

  fetch_sequencer #(.FETCH_WAIT(2)) u1 (
    .clk(clk), .reset(rst1), .cu_done(cu1), .branch_taken(br1), .branch_target(tgt1),
    .halt_req(hreq1), .resume(res1), .pc(pc1), .rom_read_enable(rom1), .ir_load(ir1),
    .state(st1), .halted(halt1), .retired(ret1)
  );

  // Instance 2: 4-bit pc, reset vector at the top of the space
  logic       rst2 = 1'b1, cu2 = 1'b0, br2 = 1'b0, hreq2 = 1'b0, res2 = 1'b0;
  logic [3:0] tgt2 = 4'h0, pc2;
  logic       rom2, ir2, halt2;
  logic [2:0] st2;
  logic [15:0] ret2;

  fetch_sequencer #(.PC_WIDTH(4), .RESET_PC(4'hF)) u2 (
    .clk(clk), .reset(rst2), .cu_done(cu2), .branch_taken(br2), .branch_target(tgt2),
    .halt_req(hreq2), .resume(res2), .pc(pc2), .rom_read_enable(rom2), .ir_load(ir2),
    .state(st2), .halted(halt2), .retired(ret2)
  );

  int exp_st [9] = '{1, 3, 4, 1, 3, 4, 1, 3, 4};
  int rom_cnt;
  int ir_cnt;

  initial begin
    // Reset state of instance 0
    @(negedge clk);
    check("rst_state", st0, 0);
    check("rst_pc", pc0, 0);
    check("rst_retired", ret0, 0);
    check("rst_rom", rom0, 0);
    check("rst_ir", ir0, 0);
    check("rst_halted", halt0, 0);
    check("rst_pc_u2", pc2, 4'hF);

    // Back-to-back instructions, cu_done tied high
    cu0  = 1'b1;
    rst0 = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      check($sformatf("seq_state%0d", n), st0, exp_st[n-1]);
      if (exp_st[n-1] == 1) check($sformatf("seq_pc%0d", n), pc0, (n - 1) / 3);
    end
    @(negedge clk);
    check("seq_state10", st0, 1);
    check("seq_pc10", pc0, 3);
    check("seq_retired3", ret0, 3);

    // Branch taken on retire
    @(negedge clk);
    check("br_decode", st0, 3);
    @(negedge clk);
    check("br_execute", st0, 4);
    br0  = 1'b1;
    tgt0 = 8'h40;
    @(negedge clk);
    br0 = 1'b0;
    check("br_state", st0, 1);
    check("br_pc", pc0, 8'h40);
    check("br_retired", ret0, 4);

    // Halt after retire, halt_req held to confirm it is ignored while halted
    @(negedge clk);
    @(negedge clk);
    check("halt_pre_exec", st0, 4);
    hreq0 = 1'b1;
    @(negedge clk);
    check("halt_state", st0, 5);
    check("halt_flag", halt0, 1);
    check("halt_pc", pc0, 8'h41);
    check("halt_retired", ret0, 5);
    rom_cnt = 0;
    for (int n = 0; n < 10; n++) begin
      rom_cnt += int'(rom0);
      @(negedge clk);
    end
    check("halt_rom_quiet", rom_cnt, 0);
    check("halt_still", st0, 5);
    check("halt_pc_held", pc0, 8'h41);
    check("halt_ret_held", ret0, 5);
    res0 = 1'b1;
    @(negedge clk);
    res0  = 1'b0;
    hreq0 = 1'b0;
    check("resume_state", st0, 1);
    check("resume_halted", halt0, 0);
    check("resume_rom", rom0, 1);

    // Wait states with a stretched execute phase
    rst1 = 1'b0;
    rom_cnt = 0;
    ir_cnt  = 0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      rom_cnt += int'(rom1);
      ir_cnt  += int'(ir1);
      if (n == 1) check("ws_fetch", st1, 1);
      if (n == 2) check("ws_wait", st1, 2);
      if (n == 4) check("ws_decode_ir", ir1, 1);
      if (n >= 5) check($sformatf("ws_exec_pc%0d", n), pc1, 0);
    end
    check("ws_rom_cycles", rom_cnt, 3);
    check("ws_ir_pulses", ir_cnt, 1);
    check("ws_exec_state", st1, 4);
    check("ws_ret_before", ret1, 0);
    cu1 = 1'b1;
    @(negedge clk);
    cu1 = 1'b0;
    check("ws_refetch", st1, 1);
    check("ws_pc_after", pc1, 1);
    check("ws_retired", ret1, 1);

    // Async reset mid-WAIT, away from any clock edge
    @(negedge clk);
    check("ar_in_wait", st1, 2);
    #2;
    rst1 = 1'b1;
    #1;
    check("ar_state", st1, 0);
    check("ar_pc", pc1, 0);
    check("ar_retired", ret1, 0);
    check("ar_rom", rom1, 0);

    // pc wrap in a 4-bit space
    cu2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    @(negedge clk);
    check("wrap_fetch_pc", pc2, 4'hF);
    @(negedge clk);
    @(negedge clk);
    check("wrap_exec", st2, 4);
    @(negedge clk);
    check("wrap_state", st2, 1);
    check("wrap_pc", pc2, 4'h0);
    check("wrap_retired", ret2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
